// File: rtl/tlb_op_ctrl_pkg.sv
// Shared definitions for the TLB instruction controller: CSR field widths,
// TLB op encodings, INVTLB limits and controller FSM states.
package tlb_op_ctrl_pkg;

  // CSR.TLBIDX index field width; also the width of every TLB index port
  localparam int TLBIDX_INDEX_W = 5;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [4:0] INVTLB_OP_MAX = 5'd6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SRCH_REQ  = 3'd1,
    S_SRCH_WAIT = 3'd2,
    S_EXEC      = 3'd3,
    S_DONE      = 3'd4
  } tlb_state_e;

  function automatic logic op_is_exec(input logic [2:0] op);
    return (op == OP_WR) || (op == OP_FILL) || (op == OP_INV);
  endfunction

endpackage

// File: rtl/tlb_rand_lfsr.sv
// Free-running 5-bit Fibonacci LFSR, polynomial x^5+x^3+1 (period 31).
// Seeded with 1 so the all-zero lock-up state is never reached.
module tlb_rand_lfsr (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [4:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= 5'b00001;
    end else if (en) begin
      value <= {value[3:0], value[4] ^ value[2]};
    end
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBSRCH/RD/WR/FILL/INVTLB instructions: issues search lookups and
// single-cycle commands to address translation, then reports completion.
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLBNUM = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_inv_op,
  input  logic [9:0]  req_inv_asid,
  input  logic [18:0] req_inv_vpn,
  input  logic        flush,
  output logic        tlbwr_en,
  output logic        tlbfill_en,
  output logic        invtlb_en,
  output logic [4:0]  rand_index,
  output logic [4:0]  invtlb_op,
  output logic [9:0]  invtlb_asid,
  output logic [18:0] invtlb_vpn,
  output logic        srch_fetch,
  input  logic        srch_found,
  input  logic [4:0]  srch_index,
  output logic        done_valid,
  output logic [2:0]  done_op,
  output logic        done_hit,
  output logic [4:0]  done_index,
  output logic        done_ine
);

  // Folds the LFSR into the table range for smaller power-of-two TLBs
  localparam logic [TLBIDX_INDEX_W-1:0] IDX_MASK = TLBIDX_INDEX_W'(TLBNUM - 1);

  tlb_state_e state, state_nxt;

  logic [2:0]  op_q;
  logic        ine_q;
  logic        found_q;
  logic [4:0]  sidx_q;
  logic [4:0]  fill_idx_q;
  logic [4:0]  inv_op_q;
  logic [9:0]  inv_asid_q;
  logic [18:0] inv_vpn_q;
  logic [4:0]  lfsr_val;
  logic        take_req;

  tlb_rand_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .value (lfsr_val)
  );

  // A flush in the accept cycle drops the request entirely
  assign take_req = (state == S_IDLE) && req_valid && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (take_req) begin
          if (req_op == OP_SRCH) begin
            state_nxt = S_SRCH_REQ;
          end else if (op_is_exec(req_op)) begin
            state_nxt = S_EXEC;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_SRCH_REQ:  state_nxt = flush ? S_IDLE : S_SRCH_WAIT;
      S_SRCH_WAIT: state_nxt = flush ? S_IDLE : S_DONE;
      S_EXEC:      state_nxt = flush ? S_IDLE : S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Operands are captured at accept; the FILL index is frozen on EXEC entry
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      ine_q      <= 1'b0;
      found_q    <= 1'b0;
      sidx_q     <= '0;
      fill_idx_q <= 5'd1;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vpn_q  <= '0;
    end else begin
      if (take_req) begin
        op_q       <= req_op;
        ine_q      <= (req_op > OP_INV) ||
                      ((req_op == OP_INV) && (req_inv_op > INVTLB_OP_MAX));
        found_q    <= 1'b0;
        sidx_q     <= '0;
        fill_idx_q <= lfsr_val & IDX_MASK;
        inv_op_q   <= req_inv_op;
        inv_asid_q <= req_inv_asid;
        inv_vpn_q  <= req_inv_vpn;
      end
      if (state == S_SRCH_WAIT) begin
        found_q <= srch_found;
        sidx_q  <= srch_index;
      end
    end
  end

  always_comb begin
    req_ready   = 1'b0;
    srch_fetch  = 1'b0;
    tlbwr_en    = 1'b0;
    tlbfill_en  = 1'b0;
    invtlb_en   = 1'b0;
    done_valid  = 1'b0;
    done_op     = '0;
    done_hit    = 1'b0;
    done_index  = '0;
    done_ine    = 1'b0;
    rand_index  = 5'd1;
    invtlb_op   = '0;
    invtlb_asid = '0;
    invtlb_vpn  = '0;
    if (!reset) begin
      req_ready   = (state == S_IDLE);
      srch_fetch  = (state == S_SRCH_REQ);
      invtlb_op   = inv_op_q;
      invtlb_asid = inv_asid_q;
      invtlb_vpn  = inv_vpn_q;
      rand_index  = (state == S_EXEC) ? fill_idx_q : (lfsr_val & IDX_MASK);
      if ((state == S_EXEC) && !flush) begin
        tlbwr_en   = (op_q == OP_WR);
        tlbfill_en = (op_q == OP_FILL);
        invtlb_en  = (op_q == OP_INV) && !ine_q;
      end
      if ((state == S_DONE) && !flush) begin
        done_valid = 1'b1;
        done_op    = op_q;
        done_ine   = ine_q;
        if (op_q == OP_SRCH) begin
          done_hit   = found_q;
          done_index = sidx_q;
        end
      end
    end
  end

endmodule
